// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and decode helpers for the load/store unit.
package lsu_pkg;

    // RV32I funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // wrap_mem access sizes
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} lsu_state_t;

    // Control fields latched with an accepted request
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] size;
    } lsu_ctl_t;

    // funct3[1:0] already encodes the access size for every legal op
    function automatic logic [1:0] f3_to_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~a[0];
            SZ_WORD: return (a == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// lsu_load_ext: sign/zero extension of right-justified load data by funct3.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    // Extend byte/half loads; word loads pass straight through
    always_comb begin
        result = raw;
        case (funct3)
            F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
            F3_LBU:  result = {24'h0, raw[7:0]};
            F3_LHU:  result = {16'h0, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of wrap_mem.
// Build macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned legal accesses
// are performed as a run of byte accesses instead of being reported as faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_misaligned,
    output logic              rsp_illegal,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rd_data
);

    lsu_state_t        state_q, state_d;
    lsu_ctl_t          ctl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              req_legal, req_aligned;
    logic [DATA_W-1:0] ext_raw, ext_res;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] raw_q, raw_next;
    logic              split_last;
`endif

    assign req_legal   = is_legal(req_we, req_funct3);
    assign req_aligned = is_aligned(f3_to_size(req_funct3), req_addr[1:0]);
    assign rsp_valid   = (state_q == RESP);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign split_last = (cnt_q == ((ctl_q.size == SZ_HALF) ? 2'd1 : 2'd3));

    // Splice the byte returned this cycle into the partially assembled load word
    always_comb begin
        raw_next = raw_q;
        raw_next[{cnt_q, 3'b000} +: 8] = mem_rd_data[7:0];
    end
`endif

    lsu_load_ext u_ext (
        .funct3 (ctl_q.funct3),
        .raw    (ext_raw),
        .result (ext_res)
    );

    // Next-state decode and memory port drive; writes are cut off by rst at once
    always_comb begin
        state_d     = state_q;
        req_ready   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_en   = 1'b0;
        mem_size    = SZ_BYTE;
        ext_raw     = mem_rd_data;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!req_legal)
                        state_d = RESP;
                    else if (req_aligned)
                        state_d = ACCESS;
                    else
`ifdef LSU_MISALIGN_SPLIT_EN
                        state_d = SPLIT;
`else
                        state_d = RESP;
`endif
                end
            end
            ACCESS: begin
                mem_addr    = addr_q;
                mem_wr_data = wdata_q;
                mem_wr_en   = ctl_q.we & ~rst;
                mem_size    = ctl_q.size;
                state_d     = RESP;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            SPLIT: begin
                mem_addr    = addr_q + ADDR_W'(cnt_q);
                mem_wr_data = DATA_W'(wdata_q[{cnt_q, 3'b000} +: 8]);
                mem_wr_en   = ctl_q.we & ~rst;
                ext_raw     = raw_next;
                if (split_last)
                    state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request capture, split bookkeeping and registered response fields
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            rsp_illegal    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cnt_q          <= '0;
            raw_q          <= '0;
`endif
        end else begin
            if (state_q == IDLE && req_valid) begin
                ctl_q       <= '{we: req_we, funct3: req_funct3, size: f3_to_size(req_funct3)};
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                rsp_rdata   <= '0;
                rsp_illegal <= ~req_legal;
`ifdef LSU_MISALIGN_SPLIT_EN
                rsp_misaligned <= 1'b0;
                cnt_q          <= '0;
                raw_q          <= '0;
`else
                rsp_misaligned <= req_legal & ~req_aligned;
`endif
            end
            if (state_q == ACCESS && !ctl_q.we)
                rsp_rdata <= ext_res;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == SPLIT) begin
                cnt_q <= cnt_q + 2'd1;
                raw_q <= raw_next;
                if (split_last && !ctl_q.we)
                    rsp_rdata <= ext_res;
            end
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, randomized model comparison and reset-abort
// sequence for load_store_unit against a 16-word byte memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misaligned, rsp_illegal;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
    logic        mem_wr_en;
    logic [1:0]  mem_size;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_illegal(rsp_illegal),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_size(mem_size), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // 16-word memory: combinational right-justified read, posedge write
    bit [7:0] tb_mem [64];
    bit [7:0] ref_mem [64];
    int       wr_count = 0;
    int       checks = 0;
    int       failures = 0;

    always_comb begin
        mem_rd_data = '0;
        case (mem_size)
            2'b00: mem_rd_data = {24'h0, tb_mem[mem_addr[5:0]]};
            2'b01: mem_rd_data = {16'h0, tb_mem[6'(mem_addr[5:0] + 6'd1)], tb_mem[mem_addr[5:0]]};
            default: mem_rd_data = {tb_mem[6'(mem_addr[5:0] + 6'd3)], tb_mem[6'(mem_addr[5:0] + 6'd2)],
                                    tb_mem[6'(mem_addr[5:0] + 6'd1)], tb_mem[mem_addr[5:0]]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            wr_count <= wr_count + 1;
            tb_mem[mem_addr[5:0]] <= mem_wr_data[7:0];
            if (mem_size != 2'b00)
                tb_mem[6'(mem_addr[5:0] + 6'd1)] <= mem_wr_data[15:8];
            if (mem_size == 2'b10) begin
                tb_mem[6'(mem_addr[5:0] + 6'd2)] <= mem_wr_data[23:16];
                tb_mem[6'(mem_addr[5:0] + 6'd3)] <= mem_wr_data[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: access semantics from the ISA rules on a flat byte array
    task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd,
                             output logic [31:0] rdata, output logic ill, mis,
                             output int lat, writes);
        int     nb;
        bit     legal;
        longint v;
        legal  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb     = 1 << f3[1:0];
        rdata  = 0;
        ill    = !legal;
        mis    = 0;
        writes = 0;
        lat    = 1;
        if (!legal) return;
        if (addr % nb != 0) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            lat = nb + 1;
            if (we) writes = nb;
`else
            mis = 1;
            return;
`endif
        end else begin
            lat = 2;
            if (we) writes = 1;
        end
        if (we) begin
            for (int i = 0; i < nb; i++)
                ref_mem[(addr + 32'(i)) & 32'h3F] = 8'(wd >> (8 * i));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++)
                v += longint'(ref_mem[(addr + 32'(i)) & 32'h3F]) << (8 * i);
            if (f3 < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v -= longint'(1) << (8 * nb);
            rdata = 32'(v);
        end
    endtask

    // Issue one request and collect the response plus observed latency/writes
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd,
                           output logic [31:0] rdata, output logic ill, mis,
                           output int lat, writes);
        int w0;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        w0 = wr_count;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=none expected=rsp_valid within 12 cycles");
        end
        rdata = rsp_rdata; ill = rsp_illegal; mis = rsp_misaligned;
        chk("ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        writes = wr_count - w0;
    endtask

    task automatic cmp(input string tag, input logic [31:0] rd, input logic il, mi, input int la, wr,
                       input logic [31:0] erd, input logic eil, emi, input int ela, ewr);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_illegal"}, 32'(il), 32'(eil));
        chk({tag, "_misaligned"}, 32'(mi), 32'(emi));
        chk({tag, "_latency"}, 32'(la), 32'(ela));
        chk({tag, "_writes"}, 32'(wr), 32'(ewr));
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        logic        ill, mis;
        int          lat, writes;
    } vec_t;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, wdata, rdata,
                                logic ill, mis, int lat, writes);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ill = ill; v.mis = mis; v.lat = lat; v.writes = writes;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd, mrd;
        logic        il, mi, mil, mmi;
        int          la, wr, mla, mwr, bad;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_misaligned", 32'(rsp_misaligned), 0);
        chk("rst_rsp_illegal", 32'(rsp_illegal), 0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 1);

        //             we f3    addr           wdata          rdata          il mi lat wr
        tbl.push_back(mk(1, 3'd2, 32'd8,  32'hDEADBEEF, 32'h0,        0, 0, 2, 1));
        tbl.push_back(mk(0, 3'd2, 32'd8,  32'h0,        32'hDEADBEEF, 0, 0, 2, 0));
        tbl.push_back(mk(1, 3'd0, 32'd5,  32'h80,       32'h0,        0, 0, 2, 1));
        tbl.push_back(mk(0, 3'd0, 32'd5,  32'h0,        32'hFFFFFF80, 0, 0, 2, 0));
        tbl.push_back(mk(0, 3'd4, 32'd5,  32'h0,        32'h00000080, 0, 0, 2, 0));
        tbl.push_back(mk(1, 3'd1, 32'd6,  32'h8001,     32'h0,        0, 0, 2, 1));
        tbl.push_back(mk(0, 3'd1, 32'd6,  32'h0,        32'hFFFF8001, 0, 0, 2, 0));
        tbl.push_back(mk(0, 3'd5, 32'd6,  32'h0,        32'h00008001, 0, 0, 2, 0));
        tbl.push_back(mk(0, 3'd2, 32'd4,  32'h0,        32'h80018000, 0, 0, 2, 0));
`ifdef LSU_MISALIGN_SPLIT_EN
        tbl.push_back(mk(1, 3'd2, 32'd5,  32'hA1B2C3D4, 32'h0,        0, 0, 5, 4));
        tbl.push_back(mk(0, 3'd2, 32'd5,  32'h0,        32'hA1B2C3D4, 0, 0, 5, 0));
        tbl.push_back(mk(0, 3'd1, 32'd7,  32'h0,        32'hFFFFA1B2, 0, 0, 3, 0));
`else
        tbl.push_back(mk(1, 3'd2, 32'd5,  32'hA1B2C3D4, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd2, 32'd5,  32'h0,        32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd1, 32'd7,  32'h0,        32'h0,        0, 1, 1, 0));
`endif
        tbl.push_back(mk(0, 3'd3, 32'd0,  32'h0,        32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(1, 3'd4, 32'd0,  32'h12345678, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(1, 3'd5, 32'd1,  32'h12345678, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(1, 3'd6, 32'd2,  32'h12345678, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(0, 3'd4, 32'd9,  32'h0,        32'h000000BE, 0, 0, 2, 0));
        tbl.push_back(mk(0, 3'd0, 32'd10, 32'h0,        32'hFFFFFFAD, 0, 0, 2, 0));

        foreach (tbl[i]) begin
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, il, mi, la, wr);
            cmp($sformatf("vec%0d", i), rd, il, mi, la, wr,
                tbl[i].rdata, tbl[i].ill, tbl[i].mis, tbl[i].lat, tbl[i].writes);
            model_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, mil, mmi, mla, mwr);
        end

        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd;
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63)) | (($urandom_range(0, 3) == 0) ? 32'hFFFFFFC0 : 32'h0);
            wd   = $urandom;
            model_txn(we, f3, addr, wd, mrd, mil, mmi, mla, mwr);
            run_txn(we, f3, addr, wd, rd, il, mi, la, wr);
            cmp($sformatf("rnd%0d", n), rd, il, mi, la, wr, mrd, mil, mmi, mla, mwr);
        end

        bad = 0;
        for (int i = 0; i < 64; i++)
            if (tb_mem[i] != ref_mem[i]) bad++;
        chk("mem_image_mismatches", 32'(bad), 0);

        // Reset landing in the middle of a multi-cycle store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_wdata = 32'h11223344;
`ifdef LSU_MISALIGN_SPLIT_EN
        req_addr = 32'd9;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        ref_mem[9] = 8'h44; ref_mem[10] = 8'h33;
`else
        req_addr = 32'd8;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`endif
        rst = 1'b1;
        #1 chk("abort_wr_en_at_rst", 32'(mem_wr_en), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_wr_en_hold", 32'(mem_wr_en), 0);
            chk("abort_no_rsp", 32'(rsp_valid), 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_ready", 32'(req_ready), 1);
            chk("abort_no_rsp_after", 32'(rsp_valid), 0);
        end
        for (int i = 8; i <= 12; i++)
            chk($sformatf("abort_mem%0d", i), 32'(tb_mem[i]), 32'(ref_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
